vga_plot_arbiter: RTL and testbench
===================================

// Module: vga_plot_arbiter
// PURPOSE
//  Shares the single vga_adapter pixel-write port (x, y, colour, plot) among NUM_REQ pixel producers
//  (screen clear engine, circle/diamond/square drawers). Grants are round-robin, with an optional
//  priority requester and locked bursts so one shape can draw without interleaving. Off-screen pixels
//  are clipped. Sits between the shape engines and the vga_adapter instance.
// PARAMETERS
//  NUM_REQ    3    number of requesters, 2..8
//  X_W        8    x coordinate width
//  Y_W        7    y coordinate width
//  C_W        3    colour width
//  X_MAX      159  largest visible x
//  Y_MAX      119  largest visible y
//  HI_PRI_EN  1    1: requester 0 (clear engine) wins every arbitration it enters
//  BURST_MAX  0    forced release after this many transfers under lock; 0 = unlimited
// PORTS
//  CLOCK_50    in   1              system clock
//  reset       in   1              synchronous, active-high
//  req_valid   in   NUM_REQ        requester i presents a pixel
//  req_lock    in   NUM_REQ        keep the grant after this transfer
//  req_x       in   NUM_REQ*X_W    packed; requester i uses slice [i*X_W +: X_W]
//  req_y       in   NUM_REQ*Y_W    packed, same layout
//  req_colour  in   NUM_REQ*C_W    packed, same layout
//  req_ready   out  NUM_REQ        pixel accepted when req_valid[i] & req_ready[i]
//  x           out  X_W            to vga_adapter
//  y           out  Y_W            to vga_adapter
//  colour      out  C_W            to vga_adapter
//  plot        out  1              one-cycle write strobe to vga_adapter
//  grant_id    out  clog2(NUM_REQ) current or last owner
//  busy        out  1              1 while state is GRANTED
//  clip_count  out  16             saturating count of dropped off-screen pixels
// BEHAVIOUR
//  Reset values: plot 0; x, y, colour 0; req_ready 0; grant_id 0; busy 0; clip_count 0; state IDLE;
//   rr_ptr NUM_REQ-1, so the first round-robin search starts at requester 0.
//  Reset has priority over everything. Reset mid-burst goes to IDLE next cycle, the accepted pixel is
//   not plotted, and the owner is dropped.
//  IDLE: if any req_valid, latch owner and go to GRANTED. req_ready stays 0 in IDLE (one arbitration cycle).
//   Choice: if HI_PRI_EN and req_valid[0], pick 0. Otherwise pick the first valid after rr_ptr, cyclic.
//   rr_ptr <= owner at grant.
//  GRANTED: req_ready[i] = (i == owner), combinational from state/owner only and independent of req_valid.
//   All other readies are 0.
//  Transfer: on owner valid & ready, latch the pixel into the output registers.
//   Next cycle, if x<=X_MAX and y<=Y_MAX: plot=1 with the latched x/y/colour.
//   Otherwise plot=0 and clip_count+1, saturating at 16'hFFFF.
//   Fixed latency is 1 cycle. plot is 0 in every cycle without a transfer, and x/y/colour hold.
//  Release to IDLE (next cycle) on any of:
//   - transfer with req_lock[owner]=0
//   - req_valid[owner]=0 and req_lock[owner]=0
//   - BURST_MAX!=0 and the transfer counter reaches BURST_MAX
//  While owner valid=0 and lock=1: hold the grant and stall. A priority requester does not pre-empt a lock.
//  Burst counter clears at grant and counts transfers in GRANTED.
//  There is one bubble cycle per re-arbitration. Peak rate is 1 pixel/clk inside a locked burst.
//  Coordinates are compared unsigned. No wrap; out-of-range pixels are dropped, never folded.
// STRUCTURE
//  Package vga_draw_pkg holds:
//   - SCREEN_W=160, SCREEN_H=120, X_W, Y_W, C_W
//   - typedef pixel_t {x, y, colour}
//   - arb_state_t {IDLE, GRANTED}
//  Sub-module vga_rr_picker: combinational cyclic first-one search from rr_ptr+1, plus the priority override.
//  Top level holds the FSM, owner register, burst counter, output register and clip counter.
// TESTING
//  1 Reset held 2 clks, all req_valid=1 -> plot, req_ready, busy, clip_count all 0; first grant after release is req0.
//  2 Req1 only, (10,20,5), lock=0 -> req_ready[1] at cycle 2; next cycle plot=1, x=10, y=20, colour=5; busy drops.
//  3 HI_PRI_EN=0, req1 and req2 valid continuously, lock=0 -> grant_id sequence 1,2,1,2; one plot every 2 clks.
//  4 Req2 lock=1 for 6 pixels, req1 valid -> 6 back-to-back plots from req2 while req_ready[1]=0.
//    With BURST_MAX=4 -> release after 4, req1 granted next.
//  5 Pixels (160,5) and (3,120) -> plot stays 0, clip_count=2. Preload at 16'hFFFF -> stays 16'hFFFF.
//  6 Req1 locked mid-burst, req0 raises valid -> req0 granted only after req1 lock drops.
//    Reset asserted in GRANTED -> next cycle busy=0, plot=0, all req_ready=0.

Source files
------------

// File: rtl/vga_draw_pkg.sv
// Shared types and screen constants for the VGA drawing blocks.
// The pixel fields follow the default 160x120, 3-bit colour mode of vga_adapter.
package vga_draw_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] colour;
    } pixel_t;

    typedef enum logic {
        IDLE,
        GRANTED
    } arb_state_t;

endpackage

// File: rtl/vga_rr_picker.sv
// Picks the next owner: a cyclic first-one search starting just after rr_ptr.
// When the priority override is enabled, a valid requester 0 always wins.
module vga_rr_picker #(
    parameter int NUM_REQ   = 3,
    parameter bit HI_PRI_EN = 1'b1,
    localparam int PTR_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [PTR_W-1:0]   pick,
    output logic               any_valid
);

    int   idx;
    logic found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && valid[idx[PTR_W-1:0]]) begin
                pick  = idx[PTR_W-1:0];
                found = 1'b1;
            end
        end
        if (HI_PRI_EN && valid[0]) begin
            pick = '0;
        end
    end

    assign any_valid = |valid;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the single vga_adapter pixel-write port among NUM_REQ pixel producers,
// with round-robin grants, optional requester-0 priority, locked bursts and clipping.
module vga_plot_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int C_W       = 3,
    parameter int X_MAX     = 159,
    parameter int Y_MAX     = 119,
    parameter bit HI_PRI_EN = 1'b1,
    parameter int BURST_MAX = 0,
    localparam int PTR_W    = $clog2(NUM_REQ)
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_lock,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    input  logic [NUM_REQ*C_W-1:0] req_colour,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   plot,
    output logic [PTR_W-1:0]       grant_id,
    output logic                   busy,
    output logic [15:0]            clip_count
);

    import vga_draw_pkg::*;

    arb_state_t       state;
    logic [PTR_W-1:0] owner;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] pick;
    logic             any_valid;
    logic [15:0]      burst_cnt;

    logic             owner_valid;
    logic             owner_lock;
    logic             burst_done;
    logic             in_range;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_colour;

    vga_rr_picker #(
        .NUM_REQ   (NUM_REQ),
        .HI_PRI_EN (HI_PRI_EN)
    ) u_picker (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr),
        .pick      (pick),
        .any_valid (any_valid)
    );

    assign owner_valid = req_valid[owner];
    assign owner_lock  = req_lock[owner];
    assign sel_x       = req_x[owner*X_W +: X_W];
    assign sel_y       = req_y[owner*Y_W +: Y_W];
    assign sel_colour  = req_colour[owner*C_W +: C_W];
    assign in_range    = (sel_x <= X_W'(X_MAX)) && (sel_y <= Y_W'(Y_MAX));
    assign burst_done  = (BURST_MAX != 0) && ((int'(burst_cnt) + 1) >= BURST_MAX);

    assign busy     = (state == GRANTED);
    assign grant_id = owner;

    // Ready depends only on who owns the port, so producers may use it to decide valid.
    always_comb begin
        req_ready = '0;
        if (state == GRANTED) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            rr_ptr     <= PTR_W'(NUM_REQ - 1);
            burst_cnt  <= '0;
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            clip_count <= '0;
        end else begin
            plot <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner     <= pick;
                        rr_ptr    <= pick;
                        burst_cnt <= '0;
                        state     <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (owner_valid) begin
                        x         <= sel_x;
                        y         <= sel_y;
                        colour    <= sel_colour;
                        plot      <= in_range;
                        burst_cnt <= burst_cnt + 16'd1;
                        if (!in_range && (clip_count != 16'hFFFF)) begin
                            clip_count <= clip_count + 16'd1;
                        end
                        if (!owner_lock || burst_done) begin
                            state <= IDLE;
                        end
                    end else if (!owner_lock) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: a directed vector table, hand-written burst/lock/reset
// sequences, and randomized traffic compared against a rule-level reference model.
module tb_vga_plot_arbiter;

    import vga_draw_pkg::*;

    localparam int N = 3;

    logic CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_lock;
    logic [7:0]     px [N];
    logic [6:0]     py [N];
    logic [2:0]     pc [N];
    logic [N*8-1:0] req_x;
    logic [N*7-1:0] req_y;
    logic [N*3-1:0] req_colour;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_x[g*8 +: 8]      = px[g];
        assign req_y[g*7 +: 7]      = py[g];
        assign req_colour[g*3 +: 3] = pc[g];
    end

    // Index 0: defaults, 1: no priority, 2: no priority with BURST_MAX=4
    logic [N-1:0] o_ready [3];
    logic [7:0]   o_x     [3];
    logic [6:0]   o_y     [3];
    logic [2:0]   o_c     [3];
    logic         o_plot  [3];
    logic [1:0]   o_gid   [3];
    logic         o_busy  [3];
    logic [15:0]  o_clip  [3];

    vga_plot_arbiter dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(o_ready[0]),
        .x(o_x[0]), .y(o_y[0]), .colour(o_c[0]), .plot(o_plot[0]), .grant_id(o_gid[0]),
        .busy(o_busy[0]), .clip_count(o_clip[0])
    );

    vga_plot_arbiter #(.HI_PRI_EN(1'b0)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(o_ready[1]),
        .x(o_x[1]), .y(o_y[1]), .colour(o_c[1]), .plot(o_plot[1]), .grant_id(o_gid[1]),
        .busy(o_busy[1]), .clip_count(o_clip[1])
    );

    vga_plot_arbiter #(.HI_PRI_EN(1'b0), .BURST_MAX(4)) dut_c (
        .CLOCK_50(CLOCK_50), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_x(req_x), .req_y(req_y), .req_colour(req_colour), .req_ready(o_ready[2]),
        .x(o_x[2]), .y(o_y[2]), .colour(o_c[2]), .plot(o_plot[2]), .grant_id(o_gid[2]),
        .busy(o_busy[2]), .clip_count(o_clip[2])
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic [2:0] valid;
        logic [2:0] lock;
        pixel_t     pix;
        logic [2:0] ready;
        logic       busy;
        logic       plot;
        pixel_t     opix;
        logic [1:0] gid;
        logic [15:0] clip;
    } vec_t;

    vec_t tbl [14];

    // Reference model state for dut_a (slot 0) and dut_c (slot 1)
    int m_busy [2], m_owner [2], m_ptr [2], m_burst [2], m_plot [2];
    int m_x [2], m_y [2], m_c [2], m_clip [2];
    int m_hp [2] = '{1, 0};
    int m_bm [2] = '{0, 4};

    function automatic vec_t mk(input bit rst, input bit [2:0] v, input bit [2:0] l,
                                input int ix, input int iy, input int ic,
                                input bit [2:0] rdy, input bit bz, input bit pl,
                                input int ox, input int oy, input int oc,
                                input int gid, input int clip);
        vec_t r;
        r.rst         = rst;
        r.valid       = v;
        r.lock        = l;
        r.pix.x       = 8'(ix);
        r.pix.y       = 7'(iy);
        r.pix.colour  = 3'(ic);
        r.ready       = rdy;
        r.busy        = bz;
        r.plot        = pl;
        r.opix.x      = 8'(ox);
        r.opix.y      = 7'(oy);
        r.opix.colour = 3'(oc);
        r.gid         = 2'(gid);
        r.clip        = 16'(clip);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic [2:0] v, input logic [2:0] l);
        reset     = rst;
        req_valid = v;
        req_lock  = l;
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 3'b000, 3'b000);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic modelStep(input int m);
        int w, o, idx;
        if (reset) begin
            m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = N - 1; m_burst[m] = 0; m_plot[m] = 0;
            m_x[m] = 0; m_y[m] = 0; m_c[m] = 0; m_clip[m] = 0;
            return;
        end
        m_plot[m] = 0;
        if (m_busy[m] == 0) begin
            if (req_valid != 0) begin
                w = -1;
                if (m_hp[m] != 0 && req_valid[0]) w = 0;
                else begin
                    for (int k = 1; k <= N; k++) begin
                        idx = (m_ptr[m] + k) % N;
                        if (w < 0 && req_valid[idx]) w = idx;
                    end
                end
                m_owner[m] = w; m_ptr[m] = w; m_burst[m] = 0; m_busy[m] = 1;
            end
        end else begin
            o = m_owner[m];
            if (req_valid[o]) begin
                m_x[m] = px[o]; m_y[m] = py[o]; m_c[m] = pc[o];
                if (m_x[m] <= 159 && m_y[m] <= 119) m_plot[m] = 1;
                else if (m_clip[m] < 65535) m_clip[m]++;
                m_burst[m]++;
                if (!req_lock[o] || (m_bm[m] != 0 && m_burst[m] >= m_bm[m])) m_busy[m] = 0;
            end else if (!req_lock[o]) begin
                m_busy[m] = 0;
            end
        end
    endtask

    task automatic modelCompare(input int m, input int d);
        checkOutput($sformatf("rnd%0d_ready", d), 32'(o_ready[d]), m_busy[m] != 0 ? (32'd1 << m_owner[m]) : 32'd0);
        checkOutput($sformatf("rnd%0d_busy", d), 32'(o_busy[d]), m_busy[m]);
        checkOutput($sformatf("rnd%0d_gid", d), 32'(o_gid[d]), m_owner[m]);
        checkOutput($sformatf("rnd%0d_plot", d), 32'(o_plot[d]), m_plot[m]);
        checkOutput($sformatf("rnd%0d_pix", d), {o_x[d], o_y[d], o_c[d]}, (m_x[m] << 10) | (m_y[m] << 3) | m_c[m]);
        checkOutput($sformatf("rnd%0d_clip", d), 32'(o_clip[d]), m_clip[m]);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            px[i] = '0; py[i] = '0; pc[i] = '0;
        end
        applyStimulus(1'b1, 3'b111, 3'b000);

        tbl[0]  = mk(1, 3'b111, 3'b000,  10,  20, 5, 3'b000, 0, 0,   0,   0, 0, 0, 0);
        tbl[1]  = mk(1, 3'b111, 3'b000,  10,  20, 5, 3'b000, 0, 0,   0,   0, 0, 0, 0);
        tbl[2]  = mk(0, 3'b111, 3'b000,  10,  20, 5, 3'b001, 1, 0,   0,   0, 0, 0, 0);
        tbl[3]  = mk(0, 3'b010, 3'b000,  10,  20, 5, 3'b000, 0, 0,   0,   0, 0, 0, 0);
        tbl[4]  = mk(0, 3'b010, 3'b000,  10,  20, 5, 3'b010, 1, 0,   0,   0, 0, 1, 0);
        tbl[5]  = mk(0, 3'b010, 3'b000,  10,  20, 5, 3'b000, 0, 1,  10,  20, 5, 1, 0);
        tbl[6]  = mk(0, 3'b000, 3'b000,  10,  20, 5, 3'b000, 0, 0,  10,  20, 5, 1, 0);
        tbl[7]  = mk(0, 3'b010, 3'b000, 160,   5, 3, 3'b010, 1, 0,  10,  20, 5, 1, 0);
        tbl[8]  = mk(0, 3'b010, 3'b000, 160,   5, 3, 3'b000, 0, 0, 160,   5, 3, 1, 1);
        tbl[9]  = mk(0, 3'b010, 3'b000,   3, 120, 7, 3'b010, 1, 0, 160,   5, 3, 1, 1);
        tbl[10] = mk(0, 3'b010, 3'b000,   3, 120, 7, 3'b000, 0, 0,   3, 120, 7, 1, 2);
        tbl[11] = mk(0, 3'b010, 3'b000, 159, 119, 6, 3'b010, 1, 0,   3, 120, 7, 1, 2);
        tbl[12] = mk(0, 3'b010, 3'b000, 159, 119, 6, 3'b000, 0, 1, 159, 119, 6, 1, 2);
        tbl[13] = mk(0, 3'b000, 3'b000,   0,   0, 0, 3'b000, 0, 0, 159, 119, 6, 1, 2);

        for (int r = 0; r < 14; r++) begin
            applyStimulus(tbl[r].rst, tbl[r].valid, tbl[r].lock);
            for (int i = 0; i < N; i++) begin
                px[i] = tbl[r].pix.x; py[i] = tbl[r].pix.y; pc[i] = tbl[r].pix.colour;
            end
            tick();
            checkOutput($sformatf("vec%0d_ready", r), 32'(o_ready[0]), 32'(tbl[r].ready));
            checkOutput($sformatf("vec%0d_busy", r), 32'(o_busy[0]), 32'(tbl[r].busy));
            checkOutput($sformatf("vec%0d_plot", r), 32'(o_plot[0]), 32'(tbl[r].plot));
            checkOutput($sformatf("vec%0d_pix", r), 32'({o_x[0], o_y[0], o_c[0]}), 32'(tbl[r].opix));
            checkOutput($sformatf("vec%0d_gid", r), 32'(o_gid[0]), 32'(tbl[r].gid));
            checkOutput($sformatf("vec%0d_clip", r), 32'(o_clip[0]), 32'(tbl[r].clip));
        end

        // Plain round robin between requesters 1 and 2
        doReset();
        px[1] = 8'd40; py[1] = 7'd41; pc[1] = 3'd1;
        px[2] = 8'd50; py[2] = 7'd51; pc[2] = 3'd2;
        applyStimulus(1'b0, 3'b110, 3'b000);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (k % 2 == 0) begin
                checkOutput($sformatf("rr_gid%0d", k), 32'(o_gid[1]), ((k / 2) % 2 == 0) ? 32'd1 : 32'd2);
                checkOutput($sformatf("rr_busy%0d", k), 32'(o_busy[1]), 32'd1);
                checkOutput($sformatf("rr_noplot%0d", k), 32'(o_plot[1]), 32'd0);
            end else begin
                checkOutput($sformatf("rr_plot%0d", k), 32'(o_plot[1]), 32'd1);
                checkOutput($sformatf("rr_x%0d", k), 32'(o_x[1]), ((k / 2) % 2 == 0) ? 32'd40 : 32'd50);
            end
        end

        // Locked burst from requester 2 while requester 1 waits
        doReset();
        px[1] = 8'd77; py[1] = 7'd7; pc[1] = 3'd1;
        applyStimulus(1'b0, 3'b100, 3'b100);
        tick();
        checkOutput("burst_gid_a", 32'(o_gid[0]), 32'd2);
        checkOutput("burst_gid_c", 32'(o_gid[2]), 32'd2);
        for (int k = 0; k < 6; k++) begin
            px[2] = 8'(20 + k); py[2] = 7'd30; pc[2] = 3'(k);
            applyStimulus(1'b0, 3'b110, (k < 5) ? 3'b100 : 3'b000);
            checkOutput($sformatf("burst_ready%0d", k), 32'(o_ready[0]), 32'b100);
            tick();
            checkOutput($sformatf("burst_plot%0d", k), 32'(o_plot[0]), 32'd1);
            checkOutput($sformatf("burst_x%0d", k), 32'(o_x[0]), 32'(20 + k));
            if (k < 4) begin
                checkOutput($sformatf("bmax_plot%0d", k), 32'(o_plot[2]), 32'd1);
                checkOutput($sformatf("bmax_x%0d", k), 32'(o_x[2]), 32'(20 + k));
            end
            if (k == 3) checkOutput("bmax_release", 32'(o_busy[2]), 32'd0);
            if (k == 4) begin
                checkOutput("bmax_next_gid", 32'(o_gid[2]), 32'd1);
                checkOutput("bmax_next_busy", 32'(o_busy[2]), 32'd1);
                checkOutput("bmax_idle_plot", 32'(o_plot[2]), 32'd0);
            end
        end
        checkOutput("burst_end_busy", 32'(o_busy[0]), 32'd0);

        // Lock holds against the priority requester; reset then drops the owner
        doReset();
        applyStimulus(1'b0, 3'b010, 3'b010);
        tick();
        checkOutput("lock_gid", 32'(o_gid[0]), 32'd1);
        applyStimulus(1'b0, 3'b001, 3'b010);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("stall_busy%0d", k), 32'(o_busy[0]), 32'd1);
            checkOutput($sformatf("stall_gid%0d", k), 32'(o_gid[0]), 32'd1);
            checkOutput($sformatf("stall_ready%0d", k), 32'(o_ready[0]), 32'b010);
            checkOutput($sformatf("stall_plot%0d", k), 32'(o_plot[0]), 32'd0);
        end
        applyStimulus(1'b0, 3'b001, 3'b000);
        tick();
        checkOutput("unlock_busy", 32'(o_busy[0]), 32'd0);
        tick();
        checkOutput("pri_gid", 32'(o_gid[0]), 32'd0);
        checkOutput("pri_ready", 32'(o_ready[0]), 32'b001);
        applyStimulus(1'b1, 3'b001, 3'b001);
        tick();
        checkOutput("rst_busy", 32'(o_busy[0]), 32'd0);
        checkOutput("rst_plot", 32'(o_plot[0]), 32'd0);
        checkOutput("rst_ready", 32'(o_ready[0]), 32'd0);
        reset = 1'b0;

        // Clip counter saturation from a preloaded full count
        doReset();
        force dut_a.clip_count = 16'hFFFF;
        #1;
        release dut_a.clip_count;
        px[1] = 8'd200; py[1] = 7'd3; pc[1] = 3'd4;
        applyStimulus(1'b0, 3'b010, 3'b000);
        tick();
        tick();
        checkOutput("sat_clip", 32'(o_clip[0]), 32'hFFFF);
        checkOutput("sat_plot", 32'(o_plot[0]), 32'd0);

        // Randomized traffic against the reference model
        for (int m = 0; m < 2; m++) begin
            m_busy[m] = 0; m_owner[m] = 0; m_ptr[m] = N - 1; m_burst[m] = 0; m_plot[m] = 0;
            m_x[m] = 0; m_y[m] = 0; m_c[m] = 0; m_clip[m] = 0;
        end
        for (int i = 0; i < 400; i++) begin
            reset     = (i < 2) || ($urandom_range(0, 49) == 0);
            req_valid = 3'($urandom_range(0, 7));
            req_lock  = 3'($urandom_range(0, 7));
            for (int j = 0; j < N; j++) begin
                px[j] = 8'($urandom_range(0, 175));
                py[j] = 7'($urandom_range(0, 127));
                pc[j] = 3'($urandom_range(0, 7));
            end
            @(posedge CLOCK_50);
            modelStep(0);
            modelStep(1);
            @(negedge CLOCK_50);
            if (i >= 1) begin
                modelCompare(0, 0);
                modelCompare(1, 2);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
